// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the RV32F float-to-int conversion path.
//   - rounding-mode encodings (instruction rm field / fcsr.frm)
//   - fflags bit positions, {NV,DZ,OF,UF,NX}
//   - signed 32-bit saturation constants
//   - controller state enum
//   - rm legality helper
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CONV = 2'b01,
    ST_RESP = 2'b10
  } ctrl_state_e;

  // A resolved rounding mode of 101, 110 or 111 is reserved.
  function automatic logic rm_is_illegal(input logic [2:0] rm);
    case (rm)
      3'b101, 3'b110, 3'b111: rm_is_illegal = 1'b1;
      default:                rm_is_illegal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fcvt_w_ctrl_if.sv
// fcvt_w_ctrl_if: request/response handshake bundle between the FP issue
// stage (master) and the FCVT.W.S controller (slave).
//   req_valid/req_ready : request handshake
//   req_a, req_rm, req_rd : operand, instruction rm field, destination tag
//   rsp_valid/rsp_ready : response handshake
//   rsp_data, rsp_rd, rsp_illegal : result, echoed tag, illegal-rm trap
interface fcvt_w_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [2:0]  req_rm;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_illegal;

  modport master (
    output req_valid, req_a, req_rm, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_illegal
  );

  modport slave (
    input  req_valid, req_a, req_rm, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_illegal
  );
endinterface

// File: rtl/fcvt_w_ctrl_f2i.sv
// f2i: combinational IEEE-754 single to signed 32-bit integer converter.
//   a       in  32 : single-precision operand
//   rm      in  3  : rounding mode (RNE/RTZ/RDN/RUP/RMM; others treated as RTZ)
//   d       out 32 : rounded two's-complement result (meaningless when invalid)
//   invalid out 1  : NaN, infinity, or rounded value outside [-2^31, 2^31-1]
//   of      out 1  : finite out-of-range magnitude
//   uf      out 1  : never set by integer conversion
//   nx      out 1  : raw inexact (discarded fraction was nonzero)
module f2i
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [2:0]  rm,
  output logic [31:0] d,
  output logic        invalid,
  output logic        of,
  output logic        uf,
  output logic        nx
);

  logic        sign_s;
  logic [7:0]  exp_s;
  logic [22:0] man_s;
  logic [23:0] sig_s;
  logic [63:0] fix_s;
  logic [31:0] int_s;
  logic        guard_s;
  logic        sticky_s;
  logic        inc_s;
  logic [31:0] mag_s;

  // Align the significand to a 32.32 fixed-point value, then round.
  // Exponents below 118 leave the value under 2^-8, so only sticky matters;
  // from 118 up the left shift of a 24-bit significand fits in 64 bits for
  // every exponent that can still yield a valid result (<= 158).
  always_comb begin
    sign_s   = a[31];
    exp_s    = a[30:23];
    man_s    = a[22:0];
    sig_s    = {(exp_s != 8'd0), man_s};
    fix_s    = 64'd0;
    int_s    = 32'd0;
    guard_s  = 1'b0;
    sticky_s = 1'b0;
    if (exp_s >= 8'd118) begin
      fix_s    = {40'd0, sig_s} << (exp_s - 8'd118);
      int_s    = fix_s[63:32];
      guard_s  = fix_s[31];
      sticky_s = |fix_s[30:0];
    end else begin
      sticky_s = (exp_s != 8'd0) || (man_s != 23'd0);
    end

    case (rm)
      RM_RNE:  inc_s = guard_s && (sticky_s || int_s[0]);
      RM_RTZ:  inc_s = 1'b0;
      RM_RDN:  inc_s = sign_s && (guard_s || sticky_s);
      RM_RUP:  inc_s = !sign_s && (guard_s || sticky_s);
      RM_RMM:  inc_s = guard_s;
      default: inc_s = 1'b0;
    endcase

    // Below exponent 158 the largest float is an integer < 2^31, so rounding
    // cannot carry out of range; at 158 only exactly -2^31 is representable.
    mag_s   = int_s + {31'd0, inc_s};
    invalid = (exp_s == 8'hFF) || (exp_s > 8'd158) ||
              ((exp_s == 8'd158) && !(sign_s && (man_s == 23'd0)));
    of      = invalid && (exp_s != 8'hFF);
    uf      = 1'b0;
    nx      = guard_s || sticky_s;
    if (sign_s) begin
      d = ~mag_s + 32'd1;
    end else begin
      d = mag_s;
    end
  end

endmodule

// File: rtl/fcvt_w_ctrl.sv
// fcvt_w_ctrl: FCVT.W.S sequencing controller.
// Accepts a request, resolves the rounding mode, runs the f2i datapath for
// one cycle, applies RISC-V saturation, and holds the response until taken.
// Owns the sticky fflags register, which also accepts CSR writes.
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave modport) : request/response handshake
//   csr_frm             : fcsr.frm, sampled at accept for dynamic rm
//   csr_fflags_we/wdata : CSR write to fflags, {NV,DZ,OF,UF,NX}
//   fflags              : sticky accrued flags
// Build option: FCVT_DYN_RM_EN -- when defined, rm=111 selects csr_frm;
// when undefined, rm=111 is always illegal and csr_frm is ignored.
module fcvt_w_ctrl
  import fp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fcvt_w_ctrl_if.slave        bus,
  input  logic [2:0]          csr_frm,
  input  logic                csr_fflags_we,
  input  logic [4:0]          csr_fflags_wdata,
  output logic [4:0]          fflags
);

  ctrl_state_e state_r;
  ctrl_state_e state_nxt_s;

  logic [31:0] a_r;
  logic [4:0]  rd_r;
  logic [2:0]  rm_r;
  logic        illegal_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_data_r;
  logic [4:0]  rsp_rd_r;
  logic        rsp_illegal_r;
  logic [4:0]  fflags_r;

  logic        accept_s;
  logic [2:0]  rm_res_s;
  logic [31:0] f2i_d_s;
  logic        f2i_invalid_s;
  logic        f2i_nx_s;
  logic        a_is_nan_s;
  logic [31:0] result_s;
  logic [4:0]  flags_new_s;
  logic [4:0]  fflags_nxt_s;

  assign accept_s        = bus.req_valid && (state_r == ST_IDLE);
  assign bus.req_ready   = (state_r == ST_IDLE);
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_data    = rsp_data_r;
  assign bus.rsp_rd      = rsp_rd_r;
  assign bus.rsp_illegal = rsp_illegal_r;
  assign fflags          = fflags_r;

  // Rounding-mode resolution for the request currently offered.
`ifdef FCVT_DYN_RM_EN
  always_comb begin
    if (bus.req_rm == RM_DYN) begin
      rm_res_s = csr_frm;
    end else begin
      rm_res_s = bus.req_rm;
    end
  end
`else
  // Without dynamic rounding, 111 passes through and is caught as illegal.
  always_comb begin
    rm_res_s = bus.req_rm;
  end
`endif

  f2i u_f2i (
    .a       (a_r),
    .rm      (rm_r),
    .d       (f2i_d_s),
    .invalid (f2i_invalid_s),
    .of      (),
    .uf      (),
    .nx      (f2i_nx_s)
  );

  assign a_is_nan_s = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);

  // Saturated result and the flags this conversion contributes.
  always_comb begin
    result_s    = f2i_d_s;
    flags_new_s = 5'b00000;
    if (illegal_r) begin
      result_s    = 32'h0000_0000;
      flags_new_s = 5'b00000;
    end else if (f2i_invalid_s) begin
      result_s           = (a_r[31] && !a_is_nan_s) ? INT_MIN : INT_MAX;
      flags_new_s[FF_NV] = 1'b1;
    end else begin
      result_s           = f2i_d_s;
      flags_new_s[FF_NX] = f2i_nx_s;
    end
  end

  // Sticky flags: accrual on the CONV->RESP edge merges with a coincident CSR write.
  always_comb begin
    fflags_nxt_s = fflags_r;
    if (state_r == ST_CONV) begin
      if (csr_fflags_we) begin
        fflags_nxt_s = csr_fflags_wdata | flags_new_s;
      end else begin
        fflags_nxt_s = fflags_r | flags_new_s;
      end
    end else if (csr_fflags_we) begin
      fflags_nxt_s = csr_fflags_wdata;
    end else begin
      fflags_nxt_s = fflags_r;
    end
  end

  // Next-state logic: IDLE -> CONV -> RESP -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_CONV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CONV: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request capture at accept; rm and frm are frozen here for the whole conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= 32'd0;
      rd_r      <= 5'd0;
      rm_r      <= 3'd0;
      illegal_r <= 1'b0;
    end else if (accept_s) begin
      a_r       <= bus.req_a;
      rd_r      <= bus.req_rd;
      rm_r      <= rm_res_s;
      illegal_r <= rm_is_illegal(rm_res_s);
    end
  end

  // Response registers: loaded leaving CONV, held through backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= 32'd0;
      rsp_rd_r      <= 5'd0;
      rsp_illegal_r <= 1'b0;
    end else if (state_r == ST_CONV) begin
      rsp_valid_r   <= 1'b1;
      rsp_data_r    <= result_s;
      rsp_rd_r      <= rd_r;
      rsp_illegal_r <= illegal_r;
    end else if ((state_r == ST_RESP) && bus.rsp_ready) begin
      rsp_valid_r   <= 1'b0;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags_r <= 5'b00000;
    end else begin
      fflags_r <= fflags_nxt_s;
    end
  end

endmodule
